// File: rtl/cpu65_bus_pkg.sv
// rtl/cpu65_bus_pkg.sv - shared types and constants for the 65C816 bus-cycle stage
package cpu65_bus_pkg;

  typedef enum logic [2:0] {
    SEL_PC  = 3'd0,
    SEL_AA  = 3'd1,
    SEL_STK = 3'd2,
    SEL_DP  = 3'd3,
    SEL_DXL = 3'd4,
    SEL_VEC = 3'd5
  } bus_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Vector page base; the 5-bit vector offset is OR-ed into the low bits
  localparam logic [15:0] VEC_BASE       = 16'hFFE0;
  // Emulation-mode stack lives in page 1 of bank 0
  localparam logic [7:0]  EMU_STACK_PAGE = 8'h01;

  localparam int CNT_W = 16;

endpackage

// File: rtl/cpu_bus_addr_mux.sv
// rtl/cpu_bus_addr_mux.sv - combinational 24-bit bus address former
module cpu_bus_addr_mux
  import cpu65_bus_pkg::*;
(
  input  logic [2:0]  bus_sel,
  input  logic        e6502,
  input  logic [15:0] pc,
  input  logic [16:0] aa,
  input  logic [7:0]  ab,
  input  logic [15:0] dx,
  input  logic [15:0] s,
  input  logic [7:0]  pbr,
  input  logic [4:0]  vec,
  output logic [23:0] addr
);

  logic [7:0] aa_bank;

  // Bank for absolute addressing absorbs the carry out of AAH/AAL; wraps mod 256
  assign aa_bank = ab + {7'd0, aa[16]};

  // Select the address source; reserved encodings fall back to the program counter
  always_comb begin
    addr = {pbr, pc};
    case (bus_sel_t'(bus_sel))
      SEL_PC:  addr = {pbr, pc};
      SEL_AA:  addr = {aa_bank, aa[15:0]};
      SEL_STK: addr = e6502 ? {8'h00, EMU_STACK_PAGE, s[7:0]} : {8'h00, s};
      SEL_DP:  addr = {8'h00, dx};
      SEL_DXL: addr = {ab, dx};
      SEL_VEC: addr = {8'h00, VEC_BASE | {11'd0, vec}};
      default: addr = {pbr, pc};
    endcase
  end

endmodule

// File: rtl/cpu_bus_ctrl.sv
// rtl/cpu_bus_ctrl.sv - one memory transaction per microcycle with wait states and watchdog
module cpu_bus_ctrl
  import cpu65_bus_pkg::*;
#(
  parameter int         TIMEOUT  = 255,
  parameter logic [7:0] ERR_DATA = 8'hFF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE,
  input  logic [2:0]  BUS_SEL,
  input  logic        VPA,
  input  logic        VDA,
  input  logic        WE,
  input  logic [7:0]  DO,
  input  logic [15:0] PC,
  input  logic [16:0] AA,
  input  logic [7:0]  AB,
  input  logic [15:0] DX,
  input  logic [15:0] S,
  input  logic [7:0]  PBR,
  input  logic [4:0]  VEC,
  input  logic        E6502,
  output logic [23:0] MEM_ADDR,
  output logic        MEM_WE,
  output logic [7:0]  MEM_DOUT,
  output logic        MEM_REQ,
  input  logic        MEM_ACK,
  input  logic [7:0]  MEM_DIN,
  output logic [7:0]  D_IN,
  output logic        EN,
  output logic        BUS_ERR
);

  localparam logic             WDOG_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [23:0]      mem_addr_q, mem_addr_d;
  logic             mem_we_q, mem_we_d;
  logic [7:0]       mem_dout_q, mem_dout_d;
  logic             mem_req_q, mem_req_d;
  logic [7:0]       d_in_q, d_in_d;
  logic             en_q, en_d;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [23:0]      formed_addr;

  cpu_bus_addr_mux u_addr_mux (
    .bus_sel (BUS_SEL),
    .e6502   (E6502),
    .pc      (PC),
    .aa      (AA),
    .ab      (AB),
    .dx      (DX),
    .s       (S),
    .pbr     (PBR),
    .vec     (VEC),
    .addr    (formed_addr)
  );

  assign cnt_inc = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // Next-state logic: EN and BUS_ERR are raised on entry to DONE so they are registered
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    mem_we_d   = mem_we_q;
    mem_dout_d = mem_dout_q;
    mem_req_d  = mem_req_q;
    d_in_d     = d_in_q;
    en_d       = 1'b0;
    bus_err_d  = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (CE) begin
          if (VPA || VDA) begin
            mem_addr_d = formed_addr;
            mem_we_d   = WE;
            mem_dout_d = DO;
            mem_req_d  = 1'b1;
            state_d    = REQ;
          end else begin
            en_d    = 1'b1;
            state_d = DONE;
          end
        end
      end
      REQ: begin
        if (MEM_ACK) begin
          if (!mem_we_q) begin
            d_in_d = MEM_DIN;
          end
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          cnt_d     = '0;
          en_d      = 1'b1;
          state_d   = DONE;
        end else if (WDOG_EN && (cnt_inc == WDOG_LIMIT)) begin
          d_in_d    = ERR_DATA;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          cnt_d     = '0;
          en_d      = 1'b1;
          bus_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        cnt_d     = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // State machine register with synchronous reset that abandons any pending access
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      mem_dout_q <= '0;
      mem_req_q  <= 1'b0;
      d_in_q     <= '0;
      en_q       <= 1'b0;
      bus_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
      mem_dout_q <= mem_dout_d;
      mem_req_q  <= mem_req_d;
      d_in_q     <= d_in_d;
      en_q       <= en_d;
      bus_err_q  <= bus_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign MEM_ADDR = mem_addr_q;
  assign MEM_WE   = mem_we_q;
  assign MEM_DOUT = mem_dout_q;
  assign MEM_REQ  = mem_req_q;
  assign D_IN     = d_in_q;
  assign EN       = en_q;
  assign BUS_ERR  = bus_err_q;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// tb/tb_cpu_bus_ctrl.sv - scoreboard bench for cpu_bus_ctrl
module tb_cpu_bus_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CE = 1'b0;
  logic [2:0]  BUS_SEL = 3'd0;
  logic        VPA = 1'b0;
  logic        VDA = 1'b0;
  logic        WE = 1'b0;
  logic [7:0]  DO = 8'h00;
  logic [15:0] PC = 16'h0000;
  logic [16:0] AA = 17'h0;
  logic [7:0]  AB = 8'h00;
  logic [15:0] DX = 16'h0000;
  logic [15:0] S = 16'h0000;
  logic [7:0]  PBR = 8'h00;
  logic [4:0]  VEC = 5'h00;
  logic        E6502 = 1'b0;
  logic [23:0] MEM_ADDR;
  logic        MEM_WE;
  logic [7:0]  MEM_DOUT;
  logic        MEM_REQ;
  logic        MEM_ACK = 1'b0;
  logic [7:0]  MEM_DIN = 8'hEE;
  logic [7:0]  D_IN;
  logic        EN;
  logic        BUS_ERR;

  cpu_bus_ctrl #(.TIMEOUT(4), .ERR_DATA(8'hFF)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .BUS_SEL(BUS_SEL), .VPA(VPA), .VDA(VDA),
    .WE(WE), .DO(DO), .PC(PC), .AA(AA), .AB(AB), .DX(DX), .S(S), .PBR(PBR),
    .VEC(VEC), .E6502(E6502), .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE),
    .MEM_DOUT(MEM_DOUT), .MEM_REQ(MEM_REQ), .MEM_ACK(MEM_ACK),
    .MEM_DIN(MEM_DIN), .D_IN(D_IN), .EN(EN), .BUS_ERR(BUS_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [23:0] addr;
    logic        we;
    logic [7:0]  dout;
    int          nreq;
  } req_exp_t;

  typedef struct {
    logic [7:0] din;
    logic       err;
    int         cyc;
  } en_exp_t;

  req_exp_t rq[$];
  en_exp_t  eq[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int we_leak = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Monitor: sampled on the falling edge; cycle index names the rising edge that samples the value
  initial begin
    req_exp_t cur;
    en_exp_t  ee;
    logic     prev_req;
    logic     prev_en;
    int       req_n;
    int       unstable;
    prev_req = 1'b0;
    prev_en  = 1'b0;
    req_n    = 0;
    unstable = 0;
    cur      = '{24'h0, 1'b0, 8'h00, 0};
    forever begin
      @(negedge CLK);
      if (MEM_REQ) begin
        if (!prev_req) begin
          req_n    = 1;
          unstable = 0;
          if (rq.size() == 0) begin
            chk("unexpected_req", 32'd1, 32'd0);
          end else begin
            cur = rq.pop_front();
            chk("mem_addr", {8'h0, MEM_ADDR}, {8'h0, cur.addr});
            chk("mem_we", {31'h0, MEM_WE}, {31'h0, cur.we});
            chk("mem_dout", {24'h0, MEM_DOUT}, {24'h0, cur.dout});
          end
        end else begin
          req_n++;
          if (MEM_ADDR !== cur.addr || MEM_WE !== cur.we || MEM_DOUT !== cur.dout)
            unstable++;
        end
      end else begin
        if (MEM_WE !== 1'b0) we_leak++;
        if (prev_req) begin
          chk("req_len", req_n, cur.nreq);
          chk("req_stable", unstable, 0);
        end
      end
      if (EN) begin
        chk("en_gap", {31'h0, prev_en}, 32'd0);
        if (eq.size() == 0) begin
          chk("unexpected_en", 32'd1, 32'd0);
        end else begin
          ee = eq.pop_front();
          chk("d_in", {24'h0, D_IN}, {24'h0, ee.din});
          chk("bus_err", {31'h0, BUS_ERR}, {31'h0, ee.err});
          chk("en_cycle", cyc + 1, ee.cyc);
        end
      end else begin
        if (BUS_ERR !== 1'b0) chk("bus_err_alone", {31'h0, BUS_ERR}, 32'd0);
      end
      prev_req = MEM_REQ;
      prev_en  = EN;
    end
  end

  // Issue one microcycle; ack_wait < 0 means the memory never acknowledges
  task automatic run_cycle(
    input logic [2:0]  sel,
    input logic        vpa,
    input logic        vda,
    input logic        we,
    input logic [7:0]  dout,
    input int          ack_wait,
    input logic [7:0]  rdata,
    input logic [23:0] exp_addr,
    input int          exp_nreq,
    input int          exp_lat,
    input logic [7:0]  exp_din,
    input logic        exp_err,
    input logic        hold_ce
  );
    int c0;
    @(posedge CLK); #1;
    BUS_SEL = sel; VPA = vpa; VDA = vda; WE = we; DO = dout; CE = 1'b1;
    @(posedge CLK); #1;
    c0 = cyc;
    if (!hold_ce) CE = 1'b0;
    if (vpa || vda) rq.push_back('{exp_addr, we, dout, exp_nreq});
    eq.push_back('{exp_din, exp_err, c0 + exp_lat});
    if (hold_ce) begin
      @(posedge CLK); #1;
      CE = 1'b0;
    end
    if (ack_wait >= 0) begin
      repeat (ack_wait) begin
        @(posedge CLK); #1;
      end
      MEM_ACK = 1'b1; MEM_DIN = rdata;
      @(posedge CLK); #1;
      MEM_ACK = 1'b0; MEM_DIN = 8'hEE;
    end
    repeat (exp_lat + 2) @(posedge CLK);
    VPA = 1'b0; VDA = 1'b0; WE = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_addr", {8'h0, MEM_ADDR}, 32'h0);
    chk("rst_we", {31'h0, MEM_WE}, 32'h0);
    chk("rst_dout", {24'h0, MEM_DOUT}, 32'h0);
    chk("rst_req", {31'h0, MEM_REQ}, 32'h0);
    chk("rst_din", {24'h0, D_IN}, 32'h0);
    chk("rst_en", {31'h0, EN}, 32'h0);
    chk("rst_err", {31'h0, BUS_ERR}, 32'h0);
    RST = 1'b0;

    PBR = 8'h02; PC = 16'h8000;
    run_cycle(3'b000, 1, 0, 0, 8'h00, 0, 8'h11, 24'h028000, 1, 2, 8'h11, 0, 0);
    run_cycle(3'b111, 1, 0, 0, 8'h00, 0, 8'h22, 24'h028000, 1, 2, 8'h22, 0, 0);

    AA = 17'h1_FFFE; AB = 8'hFF;
    run_cycle(3'b001, 0, 1, 0, 8'h00, 0, 8'h5A, 24'h00FFFE, 1, 2, 8'h5A, 0, 0);

    E6502 = 1'b1; S = 16'h12F0;
    run_cycle(3'b010, 0, 1, 1, 8'hC3, 3, 8'h99, 24'h0001F0, 4, 5, 8'h5A, 0, 0);
    E6502 = 1'b0;
    run_cycle(3'b010, 0, 1, 0, 8'h00, 1, 8'h33, 24'h0012F0, 2, 3, 8'h33, 0, 0);

    DX = 16'h1234;
    run_cycle(3'b011, 0, 1, 0, 8'h00, 0, 8'h44, 24'h001234, 1, 2, 8'h44, 0, 0);
    AB = 8'h7E;
    run_cycle(3'b100, 0, 1, 1, 8'h9A, 0, 8'h55, 24'h7E1234, 1, 2, 8'h44, 0, 0);

    run_cycle(3'b000, 0, 0, 0, 8'h00, -1, 8'h00, 24'h0, 0, 1, 8'h44, 0, 1);

    VEC = 5'h1C;
    run_cycle(3'b101, 0, 1, 0, 8'h00, -1, 8'h00, 24'h00FFFC, 4, 5, 8'hFF, 1, 0);
    run_cycle(3'b101, 0, 1, 0, 8'h00, 3, 8'h77, 24'h00FFFC, 4, 5, 8'h77, 0, 0);

    // Reset while the access is waiting; a late ACK must be ignored
    @(posedge CLK); #1;
    BUS_SEL = 3'b000; VPA = 1'b1; CE = 1'b1;
    @(posedge CLK); #1;
    CE = 1'b0;
    rq.push_back('{24'h028000, 1'b0, 8'h00, 2});
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    VPA = 1'b0;
    chk("rst_mid_req", {31'h0, MEM_REQ}, 32'h0);
    chk("rst_mid_en", {31'h0, EN}, 32'h0);
    @(posedge CLK); #1;
    MEM_ACK = 1'b1; MEM_DIN = 8'hAB;
    @(posedge CLK); #1;
    MEM_ACK = 1'b0; MEM_DIN = 8'hEE;
    repeat (3) @(posedge CLK);
    #1;
    chk("late_ack_din", {24'h0, D_IN}, 32'h0);

    DX = 16'h0042;
    run_cycle(3'b011, 0, 1, 0, 8'h00, 0, 8'h5C, 24'h000042, 1, 2, 8'h5C, 0, 0);

    repeat (4) @(posedge CLK);
    chk("req_queue_drained", rq.size(), 0);
    chk("en_queue_drained", eq.size(), 0);
    chk("we_without_req", we_leak, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/cpu_bus_ctrl.md
Name: cpu_bus_ctrl

Overview:
- Downstream bus-cycle stage of the 65C816 core. It consumes PC, AA, AB, DX and S from the address generator, plus PBR and the microcode cycle request.
- Forms the 24-bit bus address and runs one memory transaction per microcycle over a req/ack handshake.
- Returns read data as D_IN and produces the one-cycle EN strobe that advances the address generator and the rest of the core.
- Covers slow memory and side-bus wait states, with a watchdog timeout.

Parameters:
- TIMEOUT, 255, max REQ cycles without ack before forced completion; 0 disables the watchdog.
- ERR_DATA, 8'hFF, data returned on timeout.

Ports:
- CLK  in  1  core clock
- RST  in  1  synchronous active-high reset
- CE  in  1  microcycle start request from the core sequencer; sampled only in IDLE
- BUS_SEL  in  3  address source (see Behaviour)
- VPA  in  1  program/opcode access
- VDA  in  1  data access
- WE  in  1  write cycle
- DO  in  8  write data
- PC  in  16  program counter
- AA  in  17  {carry, AAH, AAL}
- AB  in  8  absolute bank
- DX  in  16  direct/indirect pointer
- S  in  16  stack pointer
- PBR  in  8  program bank
- VEC  in  5  vector offset
- E6502  in  1  emulation mode
- MEM_ADDR  out  24  bus address
- MEM_WE  out  1  write strobe, qualified by MEM_REQ
- MEM_DOUT  out  8  write data
- MEM_REQ  out  1  transaction request
- MEM_ACK  in  1  transaction complete
- MEM_DIN  in  8  read data
- D_IN  out  8  latched read data to the core
- EN  out  1  one-cycle core advance strobe
- BUS_ERR  out  1  one-cycle timeout flag, coincident with EN

Behaviour:
- Reset (synchronous, RST=1 at a CLK edge): state IDLE; MEM_ADDR=0, MEM_WE=0, MEM_DOUT=0, MEM_REQ=0, D_IN=0, EN=0, BUS_ERR=0; timeout counter cleared.
- A reset mid-transaction drops MEM_REQ on the next edge and discards the pending access. An ACK arriving in IDLE is ignored.
- Address formation, combinational from the inputs at CE:
  - 000: {PBR, PC}
  - 001: {AB + AA[16], AA[15:0]}; bank add is mod 256, carry out discarded
  - 010: stack. {8'h00, S} when E6502=0; {8'h00, 8'h01, S[7:0]} when E6502=1
  - 011: {8'h00, DX}
  - 100: {AB, DX}
  - 101: vector, {8'h00, 8'hFF, 3'b111, VEC}
  - 110 and 111: reserved, same as 000
- States: IDLE, REQ, DONE.
- IDLE, CE=1, VPA|VDA=1: register the formed address into MEM_ADDR, WE into MEM_WE, DO into MEM_DOUT; go to REQ.
- IDLE, CE=1, VPA=VDA=0: internal cycle, no bus activity; go to DONE. D_IN is unchanged.
- IDLE, CE=0: stay.
- REQ:
  - MEM_REQ=1. MEM_ADDR, MEM_WE and MEM_DOUT are held stable.
  - On MEM_ACK=1: latch MEM_DIN into D_IN if MEM_WE=0 (D_IN unchanged on writes); clear MEM_REQ; go to DONE.
  - Counter increments each REQ cycle without ACK. When TIMEOUT≠0 and the count reaches TIMEOUT, complete as above with D_IN=ERR_DATA and set a pending-error flag.
  - ACK on the same edge as the timeout wins: normal completion, no error.
- DONE: EN=1 for exactly one cycle, BUS_ERR=pending flag; clear the flag and counter; go to IDLE. CE is ignored in DONE and REQ.
- Latency, counted from the CE edge t0:
  - Internal cycle: EN at t1.
  - Memory access: MEM_REQ visible from t1. An ACK sampled at t1 gives EN at t2; k wait cycles give EN at t2+k.
- MEM_WE is 0 whenever MEM_REQ is 0 (registered, cleared on completion).
- EN never asserts on two consecutive cycles. Minimum CE-to-CE period is 2 cycles.

Decomposition:
- Package cpu65_bus_pkg:
  - bus_sel_t enum: SEL_PC, SEL_AA, SEL_STK, SEL_DP, SEL_DXL, SEL_VEC
  - state_t enum: IDLE, REQ, DONE
  - VEC_BASE constant 16'hFFE0
  - EMU_STACK_PAGE 8'h01
- One sub-module, cpu_bus_addr_mux: purely combinational 24-bit address former for BUS_SEL/E6502. It is unit-testable on its own.

Test Plan:
- Read: BUS_SEL=001, AA=17'h1_FFFE, AB=8'hFF, VDA=1, ACK held 1 → MEM_ADDR=24'h00FFFE at t1, MEM_REQ at t1 only, D_IN=MEM_DIN=8'h5A and EN at t2.
- Emulation stack write: BUS_SEL=010, E6502=1, S=16'h12F0, WE=1, DO=8'hC3, ACK delayed 3 cycles → MEM_ADDR=24'h0001F0, MEM_WE=1, MEM_DOUT=8'hC3 stable t1..t4, EN at t5, D_IN unchanged.
- Internal cycle: VPA=VDA=0, CE=1 → MEM_REQ never asserts, EN at t1. A CE during DONE is ignored (no second EN at t2).
- Timeout: TIMEOUT=4, vector read with VEC=5'h1C, ACK never → MEM_ADDR=24'h00FFFC, MEM_REQ t1..t4, then D_IN=8'hFF, EN=1 and BUS_ERR=1 together; no error when ACK coincides with the 4th cycle.
- Reset mid-REQ: RST at t2 during wait → MEM_REQ=0, EN=0 at t3. A late ACK at t4 produces no EN and no D_IN change.
- Program fetch: BUS_SEL=000, PBR=8'h02, PC=16'h8000, VPA=1 → MEM_ADDR=24'h028000; BUS_SEL=111 gives the same address.
